// File: rtl/stepper_seq.sv
// stepper_seq: stepper-motor phase sequencer with wave/full/half drive, rate divider and signed position.
// Define STEPPER_RELEASE_EN to de-energise the coils after HOLD_CYCLES consecutive idle cycles.
module stepper_seq #(
  parameter int POS_W       = 16,
  parameter int DIV_W       = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    dir,
  input  logic [1:0]              mode,
  input  logic [POS_W-1:0]        steps_req,
  input  logic [DIV_W-1:0]        div,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              coils,
  output logic signed [POS_W-1:0] position,
  output logic [POS_W-1:0]        steps_left
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       phase;
  logic             dir_l;
  logic [1:0]       mode_l;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] presc;
  logic             accept;
  logic             step_now;
  logic [2:0]       phase_aligned;
  logic [2:0]       phase_stepped;

  function automatic logic [3:0] phase_pattern(input logic [2:0] p);
    logic [3:0] pat;
    case (p)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Wave drive lives on even phases, full drive on odd phases, half uses all eight.
  function automatic logic [2:0] align_phase(input logic [2:0] p, input logic [1:0] m);
    logic [2:0] a;
    if (m == 2'b00)      a = p & 3'b110;
    else if (m == 2'b01) a = p | 3'b001;
    else                 a = p;
    return a;
  endfunction

  function automatic logic [2:0] advance_phase(input logic [2:0] p, input logic d,
                                               input logic [1:0] m);
    logic [2:0] stride;
    stride = m[1] ? 3'd1 : 3'd2;
    return d ? p + stride : p - stride;
  endfunction

  assign accept        = (state == IDLE) && start && !abort;
  assign step_now      = (state == RUN) && !abort && (presc == div_l);
  assign phase_aligned = align_phase(phase, mode);
  assign phase_stepped = advance_phase(phase, dir_l, mode_l);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (steps_req == '0) ? DONE : RUN;
      RUN: begin
        if (abort)                                         state_nxt = IDLE;
        else if (step_now && (steps_left == POS_W'(1)))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STEPPER_RELEASE_EN
  localparam int IDLE_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_hold;
  logic              release_now;

  // Only energised idle time counts; a released motor has nothing left to time out.
  assign idle_hold   = (state == IDLE) && !accept && (coils != 4'b0000);
  assign release_now = idle_hold && (idle_cnt == IDLE_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            idle_cnt <= '0;
    else if (idle_hold) idle_cnt <= release_now ? '0 : idle_cnt + IDLE_W'(1);
    else                idle_cnt <= '0;
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 3'd0;
      coils      <= 4'b0000;
      position   <= '0;
      steps_left <= '0;
      presc      <= '0;
      dir_l      <= 1'b0;
      mode_l     <= 2'b00;
      div_l      <= '0;
    end else if (accept) begin
      dir_l      <= dir;
      mode_l     <= mode;
      div_l      <= div;
      phase      <= phase_aligned;
      coils      <= phase_pattern(phase_aligned);
      steps_left <= steps_req;
      presc      <= '0;
    end else if (step_now) begin
      phase      <= phase_stepped;
      coils      <= phase_pattern(phase_stepped);
      position   <= dir_l ? position + POS_W'(1) : position - POS_W'(1);
      steps_left <= steps_left - POS_W'(1);
      presc      <= '0;
    end else begin
      if ((state == RUN) && !abort) presc <= presc + DIV_W'(1);
`ifdef STEPPER_RELEASE_EN
      if (release_now) coils <= 4'b0000;
`endif
    end
  end

endmodule
